// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
//   Raster timing generator for the 800x480 parallel-RGB LCD. Produces the
//   x/y coordinates and valid flag consumed by the pixel pipeline, plus the
//   panel hsync/vsync/de signals and per-line / per-frame strobes.
//   Coordinates include sync + back porch, so the active area starts at
//   x = H_SYNC+H_BACK, y = V_SYNC+V_BACK.
//
// Ports
//   clk          in   pixel clock
//   rst          in   asynchronous, active-low reset
//   en           in   pixel-clock enable; counters advance only when high
//   x            out  horizontal coordinate, 0..H_TOTAL-1
//   y            out  vertical coordinate, 0..V_TOTAL-1
//   valid        out  timing locked and running (set at a frame boundary)
//   de           out  x/y inside the active area
//   hsync        out  horizontal sync, polarity per SYNC_ACTIVE_LOW
//   vsync        out  vertical sync, polarity per SYNC_ACTIVE_LOW
//   line_start   out  one-cycle strobe when x wraps to 0
//   frame_start  out  one-cycle strobe when x and y both wrap to 0
//   frame_cnt    out  frames since reset, modulo 2^16
//                     (present only when LCD_TIMING_FRAME_CNT_EN is defined)
//
// Optional feature macro: LCD_TIMING_FRAME_CNT_EN
//
// Every output is a register loaded from the decode of the *next* x/y, so
// sync, de and strobes always describe the same cycle as the x/y beside them.

module lcd_timing_gen #(
    parameter int H_ACTIVE        = 800,
    parameter int H_FRONT         = 40,
    parameter int H_SYNC          = 48,
    parameter int H_BACK          = 40,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 13,
    parameter int V_SYNC          = 3,
    parameter int V_BACK          = 29,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        valid,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        line_start,
    output logic        frame_start
`ifdef LCD_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_START = H_SYNC + H_BACK;
    localparam int V_START = V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_X  = 11'(H_SYNC);
    localparam logic [9:0]  V_SYNC_Y  = 10'(V_SYNC);
    localparam logic [10:0] H_START_X = 11'(H_START);
    localparam logic [10:0] H_END_X   = 11'(H_START + H_ACTIVE);
    localparam logic [9:0]  V_START_Y = 10'(V_START);
    localparam logic [9:0]  V_END_Y   = 10'(V_START + V_ACTIVE);

    // Deasserted sync level equals SYNC_ACTIVE_LOW (high for an active-low panel).
    localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;

    // Map a logical "sync asserted" onto the panel pin level.
    function automatic logic sync_level(input logic asserted);
        return asserted ^ SYNC_ACTIVE_LOW;
    endfunction

    function automatic logic in_active(input logic [10:0] xv, input logic [9:0] yv);
        return (xv >= H_START_X) && (xv < H_END_X) &&
               (yv >= V_START_Y) && (yv < V_END_Y);
    endfunction

    logic        x_wrap;
    logic        frame_wrap;
    logic [10:0] x_nxt;
    logic [9:0]  y_nxt;

    always_comb begin
        x_wrap     = (x == H_LAST);
        frame_wrap = x_wrap && (y == V_LAST);
        x_nxt      = x_wrap ? 11'd0 : x + 11'd1;
        y_nxt      = y;
        if (x_wrap) begin
            y_nxt = (y == V_LAST) ? 10'd0 : y + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x           <= '0;
            y           <= '0;
            de          <= 1'b0;
            hsync       <= SYNC_OFF;
            vsync       <= SYNC_OFF;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            state       <= IDLE;
            valid       <= 1'b0;
`ifdef LCD_TIMING_FRAME_CNT_EN
            frame_cnt   <= '0;
`endif
        end else if (en) begin
            x           <= x_nxt;
            y           <= y_nxt;
            hsync       <= sync_level(x_nxt < H_SYNC_X);
            vsync       <= sync_level(y_nxt < V_SYNC_Y);
            de          <= in_active(x_nxt, y_nxt);
            line_start  <= x_wrap;
            frame_start <= frame_wrap;
            // Lock only on a frame boundary so the pipeline never sees a
            // partial frame.
            case (state)
                IDLE: begin
                    if (frame_wrap) begin
                        state <= RUN;
                        valid <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                    valid <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
`ifdef LCD_TIMING_FRAME_CNT_EN
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
`endif
        end else begin
            // Stall: coordinates and decodes hold, strobes drop, lock is lost.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            state       <= IDLE;
            valid       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Testbench for lcd_timing_gen.
// A reduced-geometry instance (15 x 8 raster, 120 cycles per frame) exercises
// full frames, a stall and an asynchronous reset; a default-geometry instance
// is used for the first line of the real 928 x 525 raster.
// Reduced geometry: H = 8 active + 2 front + 3 sync + 2 back (H_START = 5),
//                   V = 4 active + 1 front + 2 sync + 1 back (V_START = 3).

module tb_lcd_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;

    logic [10:0] s_x;
    logic [9:0]  s_y;
    logic        s_valid, s_de, s_hs, s_vs, s_ls, s_fs;
    logic [10:0] d_x;
    logic [9:0]  d_y;
    logic        d_valid, d_de, d_hs, d_vs, d_ls, d_fs;
`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [15:0] s_fc;
    logic [15:0] d_fc;
`endif

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .x(s_x), .y(s_y), .valid(s_valid), .de(s_de),
        .hsync(s_hs), .vsync(s_vs),
        .line_start(s_ls), .frame_start(s_fs)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    lcd_timing_gen dut_d (
        .clk(clk), .rst(rst), .en(en),
        .x(d_x), .y(d_y), .valid(d_valid), .de(d_de),
        .hsync(d_hs), .vsync(d_vs),
        .line_start(d_ls), .frame_start(d_fs)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(d_fc)
`endif
    );

    typedef struct {
        int edge_no;
        int x;
        int y;
        bit fs;
        bit vld;
        int fc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_no = 0;

    int k;          // active (en=1) edges since reset release
    bit vld_m;      // expected valid after the coming edge
    int fc_m;       // expected frame count

    always @(posedge clk) edge_no <= edge_no + 1;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: every strobe from the reduced DUT is matched
    // against the next expected strobe.
    always @(negedge clk) begin
        if (rst && (s_ls || s_fs)) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got ls=%0d fs=%0d at x=%0d y=%0d, expected none",
                         s_ls, s_fs, s_x, s_y);
            end else begin
                mon_e = q.pop_front();
                chk("strobe_edge", edge_no, mon_e.edge_no);
                chk("strobe_x", int'(s_x), mon_e.x);
                chk("strobe_y", int'(s_y), mon_e.y);
                chk("strobe_ls", int'(s_ls), 1);
                chk("strobe_fs", int'(s_fs), int'(mon_e.fs));
                chk("strobe_valid", int'(s_valid), int'(mon_e.vld));
`ifdef LCD_TIMING_FRAME_CNT_EN
                if (mon_e.fs) chk("frame_cnt", int'(s_fc), mon_e.fc);
`endif
            end
        end
    end

    // One enabled clock edge; queues the strobe expected from it.
    task automatic tick_en();
        exp_t e;
        k++;
        if (k % 15 == 0) begin
            e.edge_no = edge_no + 1;
            e.x  = 0;
            e.y  = (k / 15) % 8;
            e.fs = (k % 120 == 0);
            if (e.fs) begin
                vld_m = 1'b1;
                fc_m  = (fc_m + 1) % 65536;
            end
            e.vld = vld_m;
            e.fc  = fc_m;
            q.push_back(e);
        end
        en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic tick_stall();
        en    = 1'b0;
        vld_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int hs_low_d, de_cnt_d;
    int de_cnt, vs_low, hs_low, de_first, de_last;

    initial begin
        hs_low_d = 0; de_cnt_d = 0;
        de_cnt = 0; vs_low = 0; hs_low = 0; de_first = -1; de_last = -1;
        k = 0; vld_m = 1'b0; fc_m = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(s_x), 0);
        chk("rst_y", int'(s_y), 0);
        chk("rst_valid", int'(s_valid), 0);
        chk("rst_de", int'(s_de), 0);
        chk("rst_ls", int'(s_ls), 0);
        chk("rst_fs", int'(s_fs), 0);
        chk("rst_hsync", int'(s_hs), 1);
        chk("rst_vsync", int'(s_vs), 1);
        chk("rst_dflt_x", int'(d_x), 0);
        chk("rst_dflt_hsync", int'(d_hs), 1);
`ifdef LCD_TIMING_FRAME_CNT_EN
        chk("rst_frame_cnt", int'(s_fc), 0);
`endif
        rst = 1'b1;

        // Continuous run from reset
        while (k < 1027) begin
            tick_en();
            if (k == 1) begin
                chk("first_x", int'(s_x), 1);
                chk("first_y", int'(s_y), 0);
                chk("first_hsync", int'(s_hs), 0);
                chk("first_dflt_x", int'(d_x), 1);
            end
            if (k == 119) chk("pre_lock_valid", int'(s_valid), 0);
            if (k == 120) begin
                chk("lock_valid", int'(s_valid), 1);
                chk("lock_fs", int'(s_fs), 1);
            end
            if (k == 927) begin
                chk("dflt_pre_ls", int'(d_ls), 0);
                chk("dflt_pre_x", int'(d_x), 927);
            end
            if (k == 928) begin
                chk("dflt_ls", int'(d_ls), 1);
                chk("dflt_ls_x", int'(d_x), 0);
                chk("dflt_ls_y", int'(d_y), 1);
                chk("dflt_ls_fs", int'(d_fs), 0);
                chk("dflt_ls_valid", int'(d_valid), 0);
            end
            if (k >= 928 && k <= 975 && d_hs == 1'b0) hs_low_d++;
            if (k == 975) chk("dflt_hsync_low_cnt", hs_low_d, 48);
            if (k == 976) chk("dflt_hsync_x48", int'(d_hs), 1);
            if (d_de) de_cnt_d++;
            if (k >= 240 && k < 360) begin
                if (s_de) begin
                    de_cnt++;
                    if (de_first < 0) de_first = k;
                    de_last = k;
                end
                if (!s_vs) vs_low++;
                if (!s_hs) hs_low++;
            end
            if (k == 289) chk("de_x4", int'(s_de), 0);
            if (k == 290) begin
                chk("de_first_x", int'(s_x), 5);
                chk("de_first_y", int'(s_y), 3);
                chk("de_first_de", int'(s_de), 1);
                chk("de_first_valid", int'(s_valid), 1);
            end
            if (k == 297) chk("de_x12", int'(s_de), 1);
            if (k == 298) chk("de_x13", int'(s_de), 0);
        end
        chk("frame_de_cnt", de_cnt, 32);
        chk("frame_vsync_low", vs_low, 30);
        chk("frame_hsync_low", hs_low, 24);
        chk("frame_de_first", de_first, 290);
        chk("frame_de_last", de_last, 342);
        chk("dflt_no_de_rows01", de_cnt_d, 0);
        chk("stall_pt_x", int'(s_x), 7);
        chk("stall_pt_y", int'(s_y), 4);

        // Stall for 10 cycles mid-line
        for (int i = 0; i < 10; i++) begin
            tick_stall();
            chk("stall_x", int'(s_x), 7);
            chk("stall_y", int'(s_y), 4);
            chk("stall_valid", int'(s_valid), 0);
            chk("stall_strobes", int'(s_ls | s_fs), 0);
            chk("stall_de", int'(s_de), 1);
        end
        tick_en();
        chk("resume_x", int'(s_x), 8);
        chk("resume_y", int'(s_y), 4);
        chk("resume_valid", int'(s_valid), 0);
        while (k < 1089) begin
            tick_en();
            if (k == 1079) chk("relock_pre_valid", int'(s_valid), 0);
            if (k == 1080) chk("relock_valid", int'(s_valid), 1);
        end
        chk("areset_pt_x", int'(s_x), 9);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        chk("areset_x", int'(s_x), 0);
        chk("areset_y", int'(s_y), 0);
        chk("areset_valid", int'(s_valid), 0);
        chk("areset_de", int'(s_de), 0);
        chk("areset_ls", int'(s_ls), 0);
        chk("areset_fs", int'(s_fs), 0);
        chk("areset_hsync", int'(s_hs), 1);
        chk("areset_vsync", int'(s_vs), 1);
        chk("areset_dflt_x", int'(d_x), 0);
`ifdef LCD_TIMING_FRAME_CNT_EN
        chk("areset_frame_cnt", int'(s_fc), 0);
`endif
        @(posedge clk);
        #1;
        chk("areset_hold_x", int'(s_x), 0);
        rst   = 1'b1;
        k     = 0;
        vld_m = 1'b0;
        fc_m  = 0;

        // Restart after reset release
        while (k < 245) begin
            tick_en();
            if (k == 1) begin
                chk("restart_x", int'(s_x), 1);
                chk("restart_y", int'(s_y), 0);
            end
            if (k == 119) chk("restart_pre_valid", int'(s_valid), 0);
            if (k == 120) chk("restart_valid", int'(s_valid), 1);
`ifdef LCD_TIMING_FRAME_CNT_EN
            if (k == 125) begin
                force dut.frame_cnt = 16'hFFFF;
                #1;
                release dut.frame_cnt;
                #1;
                chk("frame_cnt_forced", int'(s_fc), 65535);
                fc_m = 65535;
            end
`endif
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Generates raster timing for the 800x480 parallel-RGB LCD.
- Drives the x/y coordinate and valid inputs of the pixel pipeline, plus panel hsync/vsync/de.
- Coordinates include sync + back porch, so the active area starts at x=88, y=32.
- Also issues frame and line strobes, used to refresh the note-state snapshot between frames.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 48, hsync width (pixels)
- H_BACK, 40, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FRONT, 13, vertical front porch (lines)
- V_SYNC, 3, vsync width (lines)
- V_BACK, 29, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync asserted low

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  pixel-clock enable; counters advance only when high
- x  out  11  horizontal coordinate, 0..H_TOTAL-1
- y  out  10  vertical coordinate, 0..V_TOTAL-1
- valid  out  1  timing locked and running
- de  out  1  x/y inside active area
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- line_start  out  1  one-cycle strobe when x wraps to 0
- frame_start  out  1  one-cycle strobe when x=0 and y wrap to 0
- frame_cnt  out  16  frames since reset (only with the macro below)

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK = 928
  - V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK = 525
  - H_START = H_SYNC+H_BACK = 88
  - V_START = V_SYNC+V_BACK = 32
- Reset (rst=0, asynchronous):
  - x=0, y=0, valid=0, de=0, line_start=0, frame_start=0, frame_cnt=0.
  - hsync and vsync held deasserted (high when SYNC_ACTIVE_LOW=1).
- All outputs are registered and mutually aligned: hsync, vsync, de and the strobes describe the same cycle as the x/y they accompany. Zero decode skew.
- Counting, on each clk edge with en=1:
  - x <= (x==H_TOTAL-1) ? 0 : x+1
  - On an x wrap, y <= (y==V_TOTAL-1) ? 0 : y+1; otherwise y holds.
- Decoding, all from the next x/y values:
  - hsync asserted iff x < H_SYNC.
  - vsync asserted iff y < V_SYNC.
  - de = (x >= H_START && x < H_START+H_ACTIVE && y >= V_START && y < V_START+V_ACTIVE).
  - line_start = 1 in the cycle where the new x is 0 (a wrap, not reset).
  - frame_start = 1 in the cycle where the new x=0 and new y=0 (a wrap, not reset).
- en=0:
  - x, y, hsync, vsync and de hold their values.
  - line_start and frame_start forced to 0.
  - valid cleared to 0 on the next edge.
- valid state machine, two states:
  - IDLE (valid=0) is the reset state.
  - IDLE -> RUN when frame_start is produced.
  - RUN (valid=1) -> IDLE on any edge with en=0.
  - Consequence: the pixel pipeline never sees a partial first frame, and after a stall valid returns only at the next frame boundary.
- Width and arithmetic:
  - All comparisons are unsigned.
  - Counters never exceed TOTAL-1; no overflow path.
  - Parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024. Anything else is a configuration error and needs no handling.
- After the first frame wrap, the first de=1 cycle of each frame has x=88, y=32. The last de=1 cycle has x=887, y=511.
- Releasing reset mid-frame restarts timing at x=0, y=0. There is no resynchronisation to prior state.

Optional Feature:
- Macro: LCD_TIMING_FRAME_CNT_EN
- Defined:
  - frame_cnt port exists.
  - Increments (wrapping modulo 2^16) on every cycle frame_start=1.
  - Reset to 0; holds while en=0.
- Undefined:
  - frame_cnt port and its register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then en=1 continuously:
  - First line_start at cycle 928 (x=0, y=1).
  - First frame_start at cycle 487200 (928*525).
  - valid rises with that frame_start.
- Line timing, one line in RUN:
  - hsync low for x=0..47, high at x=48.
  - de=1 for exactly 800 cycles, x=88..887, only on rows y=32..511.
- Frame timing:
  - vsync low for y=0..2.
  - Exactly 480 de lines per frame.
  - frame_start period exactly 487200 cycles.
- Drop en for 10 cycles at x=500, y=100:
  - x/y frozen at 500/100.
  - valid=0 until the next frame_start.
  - No strobes while en=0.
  - Timing resumes at x=501.
- Assert rst=0 asynchronously mid-line at x=300:
  - All outputs reach reset values before the next clk edge.
  - Release restarts counting at x=0, y=0.
- With LCD_TIMING_FRAME_CNT_EN defined, run 3 frames: frame_cnt = 0, 1, 2, 3 after each successive frame_start. Force frame_cnt to 65535 → wraps to 0.
